// File: rtl/aes_encrypt_iter.sv
// Iterative AES forward cipher: one full round per clock, valid/ready on both sides.
// The expanded key schedule comes from an external key-expansion block and must
// stay stable while the block is busy. Round key r sits at i_w[r*128 +: 128].
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for plaintext, o_in_ready high
//   S_ROUND | rounds 1..nr, one per clock; final round writes the ciphertext
//   S_DONE  | ciphertext held with o_out_valid high until the consumer takes it
module aes_encrypt_iter #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [(nr+1)*128-1:0] i_w,
  input  logic [127:0]          i_pt,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic [127:0]          o_ct,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_busy
);

  if (nr != nk + 6) begin : g_cfg_check
    $error("aes_encrypt_iter: nr must equal nk+6");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Forward S-box, entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Column in, column out; byte a0 is the top row (most significant byte).
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte n of the block lives at [127-8n -: 8]; n = 4*column + row.
  function automatic logic [127:0] shift_rows(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return y;
  endfunction

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [3:0]   r_rnd;
  logic [127:0] r_state;
  logic [127:0] r_ct;
  logic         r_out_valid;

  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_rk;
  logic [127:0] w_mid;
  logic [127:0] w_final;
  logic         w_last;

  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
    assign w_sb[gi*8 +: 8] = SBOX[r_state[gi*8 +: 8]];
  end

  assign w_sr    = shift_rows(w_sb);
  assign w_mc    = {mix_col(w_sr[127:96]), mix_col(w_sr[95:64]),
                    mix_col(w_sr[63:32]),  mix_col(w_sr[31:0])};
  assign w_rk    = i_w[32'(r_rnd) * 128 +: 128];
  assign w_mid   = w_mc ^ w_rk;
  assign w_final = w_sr ^ w_rk;
  assign w_last  = (r_rnd == 4'(nr));

  assign o_ct        = r_ct;
  assign o_out_valid = r_out_valid;

  // State register; reset always returns to idle and drops any block in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_fsm <= S_IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  // Next-state decode plus the handshake outputs that depend only on state.
  always_comb begin
    w_fsm_nxt  = r_fsm;
    o_in_ready = 1'b0;
    o_busy     = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_fsm_nxt = S_ROUND;
      end
      S_ROUND: begin
        o_busy = 1'b1;
        if (w_last) w_fsm_nxt = S_DONE;
      end
      S_DONE: begin
        o_busy = 1'b1;
        if (i_out_ready && r_out_valid) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // Datapath: initial AddRoundKey on accept, one round per clock, final round to o_ct.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rnd       <= 4'd0;
      r_state     <= '0;
      r_ct        <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (i_in_valid) begin
            r_state <= i_pt ^ i_w[127:0];
            r_rnd   <= 4'd1;
          end
        end
        S_ROUND: begin
          if (w_last) begin
            r_ct        <= w_final;
            r_out_valid <= 1'b1;
          end else begin
            r_state <= w_mid;
            r_rnd   <= r_rnd + 4'd1;
          end
        end
        S_DONE: begin
          if (i_out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter: AES-128/192/256 instances, FIPS-197 vectors.
// The key schedule is expanded here from an S-box derived arithmetically
// (GF(2^8) inverse plus affine map), independent of the table in the design.
module tb_aes_encrypt_iter;

  localparam logic [255:0] K1   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT2_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [127:0]     pt;
  logic [2:0]       iv;
  logic             out_ready;
  logic [11*128-1:0] w4;
  logic [13*128-1:0] w6;
  logic [15*128-1:0] w8;

  logic ir4, ir6, ir8, ov4, ov6, ov8, bz4, bz6, bz8;
  logic [127:0] ct4, ct6, ct8;

  aes_encrypt_iter #(.nk(4), .nr(10)) u4 (
    .i_clk(clk), .i_rst(rst), .i_w(w4), .i_pt(pt), .i_in_valid(iv[0]),
    .o_in_ready(ir4), .o_ct(ct4), .o_out_valid(ov4), .i_out_ready(out_ready), .o_busy(bz4));
  aes_encrypt_iter #(.nk(6), .nr(12)) u6 (
    .i_clk(clk), .i_rst(rst), .i_w(w6), .i_pt(pt), .i_in_valid(iv[1]),
    .o_in_ready(ir6), .o_ct(ct6), .o_out_valid(ov6), .i_out_ready(out_ready), .o_busy(bz6));
  aes_encrypt_iter #(.nk(8), .nr(14)) u8 (
    .i_clk(clk), .i_rst(rst), .i_w(w8), .i_pt(pt), .i_in_valid(iv[2]),
    .o_in_ready(ir8), .o_ct(ct8), .o_out_valid(ov8), .i_out_ready(out_ready), .o_busy(bz8));

  int checks = 0;
  int errors = 0;

  logic [1:0]   sel;
  logic         m_ov, m_ir, m_bz;
  logic [127:0] m_ct;

  // Route the selected instance's outputs to one set of observation signals.
  always_comb begin
    m_ov = ov4; m_ir = ir4; m_bz = bz4; m_ct = ct4;
    case (sel)
      2'd1: begin m_ov = ov6; m_ir = ir6; m_bz = bz6; m_ct = ct6; end
      2'd2: begin m_ov = ov8; m_ir = ir8; m_bz = bz8; m_ct = ct8; end
      default: ;
    endcase
  end

  logic [7:0]    sb [256];
  logic [31:0]   kw [60];
  logic [1919:0] wv;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Key expansion into wv, round key r at wv[r*128 +: 128].
  task automatic expand(input int nkx, input int nrx, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < nkx; i++) kw[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nkx; i < 4*(nrx+1); i++) begin
      t = kw[i-1];
      if (i % nkx == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nkx > 6 && i % nkx == 4) begin
        t = subw(t);
      end
      kw[i] = kw[i-nkx] ^ t;
    end
    wv = '0;
    for (int r = 0; r <= nrx; r++)
      wv[r*128 +: 128] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count clocks from the accepting edge until out_valid, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!m_ov && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One complete block on instance s, called at a negedge with that instance idle.
  task automatic run(input logic [1:0] s, input logic [127:0] p, input logic [127:0] exp,
                     input int lat, input bit scramble, input string tag);
    int n;
    sel = s; pt = p; iv[s] = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[s] = 1'b0;
    chk({tag, "_busy"}, 128'(m_bz), 128'(1'b1));
    chk({tag, "_in_ready_low"}, 128'(m_ir), 128'(1'b0));
    n = 0;
    while (!m_ov && n < 40) begin
      if (scramble) pt = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(lat));
    chk({tag, "_ct"}, m_ct, exp);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_cleared"}, 128'(m_ov), 128'(1'b0));
    chk({tag, "_idle_ready"}, 128'(m_ir), 128'(1'b1));
  endtask

  initial begin
    int n;
    rst = 1'b1; pt = '0; iv = 3'b000; out_ready = 1'b0; sel = 2'd0;
    w4 = '0; w6 = '0; w8 = '0;
    build_sbox();

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(ov4), 128'(1'b0));
    chk("rst_ct", ct4, 128'h0);
    chk("rst_busy", 128'(bz4), 128'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(ir4), 128'(1'b1));

    // FIPS-197 appendix B, then appendix C for all three key sizes.
    expand(4, 10, K1);    w4 = wv[11*128-1:0];
    run(2'd0, PT1, CT1, 10, 1'b0, "v1");
    expand(4, 10, K128);  w4 = wv[11*128-1:0];
    run(2'd0, PT2, CT2, 10, 1'b0, "v2_128");
    expand(6, 12, K192);  w6 = wv[13*128-1:0];
    run(2'd1, PT2, CT2_192, 12, 1'b0, "v2_192");
    expand(8, 14, K256);  w8 = wv[15*128-1:0];
    run(2'd2, PT2, CT2_256, 14, 1'b0, "v2_256");

    // Backpressure: result held for 20 clocks while new plaintext is offered.
    sel = 2'd0; pt = PT2; iv[0] = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    wait_done(n);
    chk("bp_latency", 128'(n), 128'(10));
    for (int i = 0; i < 20; i++) begin
      iv[0] = 1'(i % 2);
      pt = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("bp_ov_held", 128'(m_ov), 128'(1'b1));
      chk("bp_ct_held", m_ct, CT2);
      chk("bp_in_ready_low", 128'(m_ir), 128'(1'b0));
    end
    iv[0] = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_ready", 128'(m_ir), 128'(1'b1));
    chk("bp_release_ov", 128'(m_ov), 128'(1'b0));
    chk("bp_release_busy", 128'(m_bz), 128'(1'b0));
    chk("bp_ct_kept", m_ct, CT2);

    // Back-to-back: in_valid and out_ready held high across two blocks.
    expand(4, 10, K1); w4 = wv[11*128-1:0];
    pt = PT1; iv[0] = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(n);
    chk("b2b_lat1", 128'(n), 128'(10));
    chk("b2b_ct1", m_ct, CT1);
    expand(4, 10, K128); w4 = wv[11*128-1:0];
    pt = PT2;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_handoff_ready", 128'(m_ir), 128'(1'b1));
    chk("b2b_handoff_ov", 128'(m_ov), 128'(1'b0));
    @(posedge clk);
    @(negedge clk);
    chk("b2b_second_accept", 128'(m_bz), 128'(1'b1));
    wait_done(n);
    chk("b2b_lat2", 128'(n), 128'(10));
    chk("b2b_ct2", m_ct, CT2);
    iv[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_end_ready", 128'(m_ir), 128'(1'b1));

    // Plaintext scrambled every clock after capture.
    expand(4, 10, K1); w4 = wv[11*128-1:0];
    run(2'd0, PT1, CT1, 10, 1'b1, "scramble");

    // Reset at round 5 discards the block.
    expand(4, 10, K128); w4 = wv[11*128-1:0];
    pt = PT2; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ov", 128'(m_ov), 128'(1'b0));
    chk("midrst_ct", m_ct, 128'h0);
    chk("midrst_ready", 128'(m_ir), 128'(1'b1));
    chk("midrst_busy", 128'(m_bz), 128'(1'b0));
    repeat (12) @(negedge clk);
    chk("midrst_no_late_ov", 128'(m_ov), 128'(1'b0));
    expand(4, 10, K1); w4 = wv[11*128-1:0];
    run(2'd0, PT1, CT1, 10, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
